// File: rtl/spi_slave_cfg.sv
`timescale 1ns/1ps
// SPI slave for the register/command interface: oversamples SCK/MOSI/SSEL on clk,
// supports all four SPI modes latched per frame, and exchanges words via TX valid/ready and an RX strobe.
module spi_slave_cfg #(
  parameter int                DATA_W      = 8,
  parameter bit                MSB_FIRST   = 1'b1,
  parameter int                SYNC_STAGES = 2,
  parameter int                CNT_W       = 5,
  parameter logic [DATA_W-1:0] TX_IDLE     = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              SCK,
  input  logic              MOSI,
  input  logic              SSEL,
  output tri                MISO,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic [CNT_W-1:0]  word_count,
  output logic              frame_start,
  output logic              frame_end,
  output logic              tx_underrun,
  output logic              frame_err
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, ssel_sync, settle;
  logic sck_prev, ssel_prev, armed;
  logic sck_s, mosi_s, ssel_s;
  logic cpol, cpha;
  logic [BIT_W-1:0] bit_cnt;
  logic [DATA_W-1:0] rx_shift, tx_shift, rx_next;
  logic leading, trailing, ssel_fall, ssel_rise;
  logic start, stop, do_sample, do_shift, do_load;

  assign sck_s     = sck_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ssel_s    = ssel_sync[SYNC_STAGES-1];
  assign ssel_fall = ssel_prev & ~ssel_s;
  assign ssel_rise = ~ssel_prev & ssel_s;
  assign leading   = (sck_s != sck_prev) && (sck_prev == cpol);
  assign trailing  = (sck_s != sck_prev) && (sck_s == cpol);
  assign rx_next   = MSB_FIRST ? {rx_shift[DATA_W-2:0], mosi_s} : {mosi_s, rx_shift[DATA_W-1:1]};
  assign do_load   = (start && !mode[0]) || (do_shift && bit_cnt == '0);
  assign MISO      = (state == ACTIVE) ? (MSB_FIRST ? tx_shift[DATA_W-1] : tx_shift[0]) : 1'bz;

  // settle fills once the synchronisers hold real samples, so the reset value of SSEL cannot arm a frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      ssel_sync <= '1;
      settle    <= '0;
      sck_prev  <= 1'b0;
      ssel_prev <= 1'b1;
      armed     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      ssel_sync <= {ssel_sync[SYNC_STAGES-2:0], SSEL};
      settle    <= {settle[SYNC_STAGES-2:0], 1'b1};
      sck_prev  <= sck_s;
      ssel_prev <= ssel_s;
      if (settle[SYNC_STAGES-1] && ssel_s) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // An SSEL rise masks any SCK edge seen in the same cycle
  always_comb begin
    state_next = state;
    start      = 1'b0;
    stop       = 1'b0;
    do_sample  = 1'b0;
    do_shift   = 1'b0;
    case (state)
      IDLE: begin
        if (armed && ssel_fall) begin
          state_next = ACTIVE;
          start      = 1'b1;
        end
      end
      ACTIVE: begin
        if (ssel_rise) begin
          state_next = IDLE;
          stop       = 1'b1;
        end else begin
          do_sample = cpha ? trailing : leading;
          do_shift  = cpha ? leading : trailing;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpol        <= 1'b0;
      cpha        <= 1'b0;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      rx_data     <= '0;
      word_count  <= '0;
      rx_valid    <= 1'b0;
      tx_ready    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_ready    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_err   <= 1'b0;
      if (start) begin
        cpol        <= mode[1];
        cpha        <= mode[0];
        bit_cnt     <= '0;
        word_count  <= '0;
        frame_start <= 1'b1;
      end
      if (stop) begin
        frame_end <= 1'b1;
        frame_err <= (bit_cnt != '0);
        bit_cnt   <= '0;
      end
      if (do_sample) begin
        rx_shift <= rx_next;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt  <= '0;
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
          if (word_count != '1) word_count <= word_count + CNT_W'(1);
        end else begin
          bit_cnt <= bit_cnt + BIT_W'(1);
        end
      end
      // A load replaces the shift on a word boundary
      if (do_load) begin
        tx_shift    <= tx_valid ? tx_data : TX_IDLE;
        tx_ready    <= tx_valid;
        tx_underrun <= ~tx_valid;
      end else if (do_shift) begin
        if (MSB_FIRST) tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
        else           tx_shift <= {1'b0, tx_shift[DATA_W-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_cfg.sv
`timescale 1ns/1ps
// Self-checking bench for spi_slave_cfg: an 8-bit MSB-first and a 16-bit LSB-first slave share SCK/MOSI,
// each with its own SSEL; a frame-level model predicts words, handshakes and event pulses.
module tb_spi_slave_cfg;

  localparam int HALF  = 8;
  localparam int SETUP = 10;

  logic clk, reset, SCK, MOSI, ssel0, ssel1;
  logic [1:0] mode;
  wire miso0, miso1;
  pullup (miso0);
  pullup (miso1);

  logic [7:0]  tx_data0, rx_data0;
  logic [15:0] tx_data1, rx_data1;
  logic tx_valid0, tx_ready0, rx_valid0, frame_start0, frame_end0, tx_underrun0, frame_err0;
  logic tx_valid1, tx_ready1, rx_valid1, frame_start1, frame_end1, tx_underrun1, frame_err1;
  logic [4:0] word_count0;
  logic [2:0] word_count1;

  int vectors, miscompares;
  int fs_cnt[2], fe_cnt[2], ferr_cnt[2], rdy_cnt[2], und_cnt[2];
  logic [31:0] mosi_q[$], miso_got[$], txm_q[$], rx_seen0[$], rx_seen1[$];
  logic [7:0]  tx_q0[$];
  logic [15:0] tx_q1[$];

  spi_slave_cfg #(.DATA_W(8), .MSB_FIRST(1'b1), .SYNC_STAGES(2), .CNT_W(5), .TX_IDLE(8'hFF)) dut0 (
    .clk(clk), .reset(reset), .SCK(SCK), .MOSI(MOSI), .SSEL(ssel0), .MISO(miso0), .mode(mode),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0), .rx_data(rx_data0),
    .rx_valid(rx_valid0), .word_count(word_count0), .frame_start(frame_start0),
    .frame_end(frame_end0), .tx_underrun(tx_underrun0), .frame_err(frame_err0));

  spi_slave_cfg #(.DATA_W(16), .MSB_FIRST(1'b0), .SYNC_STAGES(3), .CNT_W(3), .TX_IDLE(16'h0000)) dut1 (
    .clk(clk), .reset(reset), .SCK(SCK), .MOSI(MOSI), .SSEL(ssel1), .MISO(miso1), .mode(mode),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1), .rx_data(rx_data1),
    .rx_valid(rx_valid1), .word_count(word_count1), .frame_start(frame_start1),
    .frame_end(frame_end1), .tx_underrun(tx_underrun1), .frame_err(frame_err1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout, expected run to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Command-decoder stand-in: presents the head of each TX queue and pops it when consumed
  initial begin
    tx_valid0 = 1'b0; tx_data0 = '0; tx_valid1 = 1'b0; tx_data1 = '0;
    forever begin
      @(negedge clk);
      if (tx_ready0 && tx_q0.size() > 0) void'(tx_q0.pop_front());
      if (tx_ready1 && tx_q1.size() > 0) void'(tx_q1.pop_front());
      tx_valid0 = (tx_q0.size() > 0);
      tx_data0  = tx_valid0 ? tx_q0[0] : 8'h00;
      tx_valid1 = (tx_q1.size() > 0);
      tx_data1  = tx_valid1 ? tx_q1[0] : 16'h0000;
    end
  end

  always @(negedge clk) begin
    if (rx_valid0) rx_seen0.push_back(32'(rx_data0));
    if (rx_valid1) rx_seen1.push_back(32'(rx_data1));
    if (frame_start0) fs_cnt[0]++;
    if (frame_end0)   fe_cnt[0]++;
    if (frame_err0)   ferr_cnt[0]++;
    if (tx_ready0)    rdy_cnt[0]++;
    if (tx_underrun0) und_cnt[0]++;
    if (frame_start1) fs_cnt[1]++;
    if (frame_end1)   fe_cnt[1]++;
    if (frame_err1)   ferr_cnt[1]++;
    if (tx_ready1)    rdy_cnt[1]++;
    if (tx_underrun1) und_cnt[1]++;
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearCounts();
    for (int d = 0; d < 2; d++) begin
      fs_cnt[d] = 0; fe_cnt[d] = 0; ferr_cnt[d] = 0; rdy_cnt[d] = 0; und_cnt[d] = 0;
    end
    rx_seen0.delete();
    rx_seen1.delete();
  endtask

  task automatic setSel(input int d, input logic v);
    if (d == 1) ssel1 = v;
    else        ssel0 = v;
  endtask

  function automatic logic mosiBit(input int k, input int w, input bit msb);
    int word, pos;
    logic [31:0] tmp;
    word = k / w;
    pos  = k % w;
    if (word >= mosi_q.size()) return 1'b0;
    tmp = mosi_q[word];
    return tmp[msb ? (w - 1 - pos) : pos];
  endfunction

  function automatic logic [31:0] idleWord(input int d);
    return (d == 1) ? 32'h0000 : 32'hFF;
  endfunction

  // Bit-level SPI master: drives mosi_q, collects MISO words into miso_got
  task automatic spiFrame(input int d, input logic [1:0] m, input int nbits);
    int w, pos, idx;
    bit msb;
    logic cpol, cpha;
    logic [31:0] cur;
    w = (d == 1) ? 16 : 8;
    msb = (d == 0);
    cpol = m[1];
    cpha = m[0];
    mode = m;
    SCK = cpol;
    MOSI = 1'b0;
    miso_got.delete();
    cur = '0;
    waitClk(8);
    if (!cpha) MOSI = mosiBit(0, w, msb);
    setSel(d, 1'b0);
    waitClk(SETUP);
    for (int k = 0; k < nbits; k++) begin
      pos = k % w;
      idx = msb ? (w - 1 - pos) : pos;
      if (!cpha) begin
        cur[idx] = (d == 1) ? miso1 : miso0;
        SCK = ~cpol;
        waitClk(HALF);
        SCK = cpol;
        MOSI = mosiBit(k + 1, w, msb);
        waitClk(HALF);
      end else begin
        SCK = ~cpol;
        MOSI = mosiBit(k, w, msb);
        waitClk(HALF);
        cur[idx] = (d == 1) ? miso1 : miso0;
        SCK = cpol;
        waitClk(HALF);
      end
      if (pos == w - 1) begin
        miso_got.push_back(cur);
        cur = '0;
      end
    end
    setSel(d, 1'b1);
    waitClk(12);
  endtask

  // Frame-level model: one load per word boundary (plus the closing load in cpha=0),
  // each load taking the next queued TX word or the idle word
  task automatic checkFrame(input int d, input logic [1:0] m, input int nbits);
    int w, nw, part, loads, pushed, rdy, maxc;
    logic [31:0] got, exp;
    w = (d == 1) ? 16 : 8;
    nw = nbits / w;
    part = (nbits % w != 0) ? 1 : 0;
    loads = m[0] ? (nw + part) : (nw + 1);
    pushed = txm_q.size();
    rdy = (loads < pushed) ? loads : pushed;
    maxc = (d == 1) ? 7 : 31;
    checkOutput($sformatf("d%0d_m%0d_frame_start", d, m), fs_cnt[d], 1);
    checkOutput($sformatf("d%0d_m%0d_frame_end", d, m), fe_cnt[d], 1);
    checkOutput($sformatf("d%0d_m%0d_frame_err", d, m), ferr_cnt[d], part);
    checkOutput($sformatf("d%0d_m%0d_tx_ready", d, m), rdy_cnt[d], rdy);
    checkOutput($sformatf("d%0d_m%0d_tx_underrun", d, m), und_cnt[d], loads - rdy);
    checkOutput($sformatf("d%0d_m%0d_rx_count", d, m), (d == 1) ? rx_seen1.size() : rx_seen0.size(), nw);
    checkOutput($sformatf("d%0d_m%0d_word_count", d, m),
                (d == 1) ? 32'(word_count1) : 32'(word_count0), (nw < maxc) ? nw : maxc);
    for (int i = 0; i < nw; i++) begin
      if (d == 1) got = (i < rx_seen1.size()) ? rx_seen1[i] : 'x;
      else        got = (i < rx_seen0.size()) ? rx_seen0[i] : 'x;
      checkOutput($sformatf("d%0d_m%0d_rx_word%0d", d, m, i), got, mosi_q[i]);
      exp = (i < pushed) ? txm_q[i] : idleWord(d);
      checkOutput($sformatf("d%0d_m%0d_miso_word%0d", d, m, i), miso_got[i], exp);
    end
    if (nw > 0)
      checkOutput($sformatf("d%0d_m%0d_rx_data", d, m),
                  (d == 1) ? 32'(rx_data1) : 32'(rx_data0), mosi_q[nw - 1]);
  endtask

  task automatic applyStimulus(input int d, input logic [1:0] m, input int nbits);
    tx_q0.delete();
    tx_q1.delete();
    foreach (txm_q[i]) begin
      if (d == 1) tx_q1.push_back(txm_q[i][15:0]);
      else        tx_q0.push_back(txm_q[i][7:0]);
    end
    waitClk(2);
    clearCounts();
    spiFrame(d, m, nbits);
    checkFrame(d, m, nbits);
    tx_q0.delete();
    tx_q1.delete();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_rx_data0"}, 32'(rx_data0), 32'h0);
    checkOutput({tag, "_word_count0"}, 32'(word_count0), 32'h0);
    checkOutput({tag, "_pulses0"},
                {26'd0, rx_valid0, tx_ready0, frame_start0, frame_end0, tx_underrun0, frame_err0}, 32'h0);
    checkOutput({tag, "_miso0_released"}, {31'd0, miso0}, 32'h1);
    checkOutput({tag, "_rx_data1"}, 32'(rx_data1), 32'h0);
    checkOutput({tag, "_word_count1"}, 32'(word_count1), 32'h0);
    checkOutput({tag, "_pulses1"},
                {26'd0, rx_valid1, tx_ready1, frame_start1, frame_end1, tx_underrun1, frame_err1}, 32'h0);
    checkOutput({tag, "_miso1_released"}, {31'd0, miso1}, 32'h1);
  endtask

  function automatic logic [31:0] randWord(input int d);
    return (d == 1) ? ($urandom & 32'hFFFF) : ($urandom & 32'hFF);
  endfunction

  initial begin
    int d, nw, ntx;
    logic [1:0] m;
    vectors = 0; miscompares = 0;
    reset = 1'b1; SCK = 1'b0; MOSI = 1'b0; ssel0 = 1'b1; ssel1 = 1'b1; mode = 2'b00;
    clearCounts();
    waitClk(3);
    checkResetState("reset");
    reset = 1'b0;
    waitClk(10);

    $display("[TB] mode 0 single word, 8-bit MSB first");
    mosi_q = '{32'hA5};
    txm_q  = '{32'h3C};
    applyStimulus(0, 2'b00, 8);

    $display("[TB] modes 1..3, two-word frames");
    for (int mi = 1; mi < 4; mi++) begin
      mosi_q = '{32'h12, 32'h34};
      txm_q  = '{32'h56, 32'h78};
      applyStimulus(0, 2'(mi), 16);
    end

    $display("[TB] 16-bit LSB first");
    mosi_q = '{32'hBEEF};
    txm_q  = '{32'hC3A1};
    applyStimulus(1, 2'b00, 16);
    mosi_q = '{randWord(1), randWord(1)};
    txm_q  = '{randWord(1), randWord(1), randWord(1)};
    applyStimulus(1, 2'b11, 32);

    $display("[TB] TX underrun for a whole frame");
    mosi_q = '{randWord(0), randWord(0)};
    txm_q.delete();
    applyStimulus(0, 2'($urandom_range(0, 3)), 16);

    $display("[TB] partial frame then recovery");
    mosi_q = '{randWord(0)};
    txm_q  = '{randWord(0)};
    applyStimulus(0, 2'b00, 5);
    mosi_q = '{32'h81};
    txm_q  = '{randWord(0)};
    applyStimulus(0, 2'b00, 8);

    $display("[TB] word_count saturation");
    mosi_q.delete();
    txm_q.delete();
    for (int i = 0; i < 9; i++) begin
      mosi_q.push_back(randWord(1));
      txm_q.push_back(randWord(1));
    end
    applyStimulus(1, 2'($urandom_range(0, 3)), 9 * 16);

    $display("[TB] randomized frames");
    for (int it = 0; it < 6; it++) begin
      d   = $urandom_range(0, 1);
      m   = 2'($urandom_range(0, 3));
      nw  = $urandom_range(1, 3);
      ntx = $urandom_range(0, nw + 1);
      mosi_q.delete();
      txm_q.delete();
      for (int i = 0; i < nw; i++) mosi_q.push_back(randWord(d));
      for (int i = 0; i < ntx; i++) txm_q.push_back(randWord(d));
      applyStimulus(d, m, nw * ((d == 1) ? 16 : 8));
    end

    $display("[TB] reset mid-frame with SSEL held low");
    tx_q0.push_back(8'h99);
    mode = 2'b00; SCK = 1'b0; MOSI = 1'b1;
    waitClk(8);
    ssel0 = 1'b0;
    waitClk(SETUP);
    for (int k = 0; k < 3; k++) begin
      SCK = 1'b1; waitClk(HALF);
      SCK = 1'b0; waitClk(HALF);
    end
    #2 reset = 1'b1;
    waitClk(2);
    checkResetState("midreset");
    tx_q0.delete();
    reset = 1'b0;
    clearCounts();
    waitClk(40);
    checkOutput("midreset_no_frame_start", fs_cnt[0], 0);
    checkOutput("midreset_miso_idle", {31'd0, miso0}, 32'h1);
    ssel0 = 1'b1;
    waitClk(20);
    mosi_q = '{randWord(0), randWord(0)};
    txm_q  = '{randWord(0), randWord(0)};
    applyStimulus(0, 2'($urandom_range(0, 3)), 16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
